// File: rtl/aplic_msi_write_engine.sv
// Turns APLIC MSI requests (address + EIID) into single-beat AXI4 writes toward the IMSIC.
// Requests are queued in a small FIFO, only one write is in flight, and error responses are counted.
module aplic_msi_write_engine #(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 4,
    parameter int ERR_W  = 8
) (
    input  logic              i_clk,
    input  logic              ni_rst,
    input  logic              i_msi_valid,
    output logic              o_msi_ready,
    input  logic [ADDR_W-1:0] i_msi_addr,
    input  logic [31:0]       i_msi_data,
    output logic              o_aw_valid,
    input  logic              i_aw_ready,
    output logic [ADDR_W-1:0] o_aw_addr,
    output logic              o_w_valid,
    input  logic              i_w_ready,
    output logic [31:0]       o_w_data,
    output logic [3:0]        o_w_strb,
    output logic              o_w_last,
    input  logic              i_b_valid,
    output logic              o_b_ready,
    input  logic [1:0]        i_b_resp,
    output logic              o_busy,
    output logic              o_err_pulse,
    output logic [ERR_W-1:0]  o_err_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [31:0]       data_mem [DEPTH];
    logic [PTR_W:0]    wr_ptr_reg;
    logic [PTR_W:0]    rd_ptr_reg;
    state_t            state_reg;
    logic              aw_pend_reg;
    logic              w_pend_reg;
    logic              b_ready_reg;
    logic              err_pulse_reg;
    logic [ADDR_W-1:0] aw_addr_reg;
    logic [31:0]       w_data_reg;
    logic [ERR_W-1:0]  err_cnt_reg;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic aw_done;
    logic w_done;
    logic unused_resp_lsb;

    // Extra wrap bit on the pointers distinguishes full from empty.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign push       = i_msi_valid && !fifo_full;
    assign pop        = (state_reg == ST_IDLE) && !fifo_empty;

    // A channel counts as done once it has no pending beat or handshakes this cycle.
    assign aw_done    = !aw_pend_reg || i_aw_ready;
    assign w_done     = !w_pend_reg || i_w_ready;

    // Only bit 1 of the response separates SLVERR/DECERR from OKAY/EXOKAY.
    assign unused_resp_lsb = i_b_resp[0];

    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg[PTR_W-1:0]] <= i_msi_addr;
            data_mem[wr_ptr_reg[PTR_W-1:0]] <= i_msi_data;
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_reg     <= ST_IDLE;
            aw_pend_reg   <= 1'b0;
            w_pend_reg    <= 1'b0;
            b_ready_reg   <= 1'b0;
            err_pulse_reg <= 1'b0;
            aw_addr_reg   <= '0;
            w_data_reg    <= '0;
            err_cnt_reg   <= '0;
        end else begin
            err_pulse_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        aw_addr_reg <= addr_mem[rd_ptr_reg[PTR_W-1:0]];
                        w_data_reg  <= data_mem[rd_ptr_reg[PTR_W-1:0]];
                        aw_pend_reg <= 1'b1;
                        w_pend_reg  <= 1'b1;
                        state_reg   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (aw_pend_reg && i_aw_ready) begin
                        aw_pend_reg <= 1'b0;
                    end
                    if (w_pend_reg && i_w_ready) begin
                        w_pend_reg <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        b_ready_reg <= 1'b1;
                        state_reg   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_b_valid) begin
                        b_ready_reg <= 1'b0;
                        state_reg   <= ST_IDLE;
                        if (i_b_resp[1]) begin
                            err_pulse_reg <= 1'b1;
                            if (err_cnt_reg != '1) begin
                                err_cnt_reg <= err_cnt_reg + ERR_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_msi_ready = !fifo_full;
    assign o_aw_valid  = aw_pend_reg;
    assign o_aw_addr   = aw_addr_reg;
    assign o_w_valid   = w_pend_reg;
    assign o_w_data    = w_data_reg;
    assign o_w_strb    = 4'hF;
    assign o_w_last    = 1'b1;
    assign o_b_ready   = b_ready_reg;
    assign o_busy      = !fifo_empty || (state_reg != ST_IDLE);
    assign o_err_pulse = err_pulse_reg;
    assign o_err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_aplic_msi_write_engine.sv
// Bench for aplic_msi_write_engine: directed scenarios plus randomized traffic against
// a queue-based scoreboard and an AXI slave with configurable backpressure.
module tb_aplic_msi_write_engine;
    localparam int ADDR_W = 64;
    localparam int DEPTH  = 4;

    logic              i_clk = 1'b0;
    logic              ni_rst = 1'b0;
    logic              i_msi_valid = 1'b0;
    logic [ADDR_W-1:0] i_msi_addr = '0;
    logic [31:0]       i_msi_data = '0;
    logic              i_aw_ready = 1'b0;
    logic              i_w_ready = 1'b0;
    logic              i_b_valid = 1'b0;
    logic [1:0]        i_b_resp = 2'b00;

    logic              o_msi_ready, o_aw_valid, o_w_valid, o_w_last, o_b_ready;
    logic              o_busy, o_err_pulse;
    logic [ADDR_W-1:0] o_aw_addr;
    logic [31:0]       o_w_data;
    logic [3:0]        o_w_strb;
    logic [7:0]        o_err_cnt;

    logic              s_msi_ready, s_aw_valid, s_w_valid, s_w_last, s_b_ready;
    logic              s_busy, s_err_pulse;
    logic [ADDR_W-1:0] s_aw_addr;
    logic [31:0]       s_w_data;
    logic [3:0]        s_w_strb;
    logic [1:0]        s_err_cnt;

    aplic_msi_write_engine #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ERR_W(8)) dut (
        .i_clk(i_clk), .ni_rst(ni_rst),
        .i_msi_valid(i_msi_valid), .o_msi_ready(o_msi_ready),
        .i_msi_addr(i_msi_addr), .i_msi_data(i_msi_data),
        .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(o_aw_addr),
        .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data),
        .o_w_strb(o_w_strb), .o_w_last(o_w_last),
        .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_resp(i_b_resp),
        .o_busy(o_busy), .o_err_pulse(o_err_pulse), .o_err_cnt(o_err_cnt)
    );

    // Narrow-counter copy driven by the same stimulus, used to observe saturation.
    aplic_msi_write_engine #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ERR_W(2)) dut_sat (
        .i_clk(i_clk), .ni_rst(ni_rst),
        .i_msi_valid(i_msi_valid), .o_msi_ready(s_msi_ready),
        .i_msi_addr(i_msi_addr), .i_msi_data(i_msi_data),
        .o_aw_valid(s_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(s_aw_addr),
        .o_w_valid(s_w_valid), .i_w_ready(i_w_ready), .o_w_data(s_w_data),
        .o_w_strb(s_w_strb), .o_w_last(s_w_last),
        .i_b_valid(i_b_valid), .o_b_ready(s_b_ready), .i_b_resp(i_b_resp),
        .o_busy(s_busy), .o_err_pulse(s_err_pulse), .o_err_cnt(s_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_aw_q[$];
    logic [31:0] exp_w_q[$];
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, exp_errs = 0, pulse_seen = 0;
    logic exp_pulse = 1'b0;
    logic accepted = 1'b0;
    logic prev_aw_wait = 1'b0, prev_w_wait = 1'b0;
    logic [63:0] prev_aw_addr = '0;
    logic [31:0] prev_w_data = '0;

    int aw_mode = 1, w_mode = 1, resp_mode = 0, b_prob = 100;
    bit b_allow = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic reset_model();
        exp_aw_q.delete();
        exp_w_q.delete();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; exp_errs = 0;
        exp_pulse = 1'b0; prev_aw_wait = 1'b0; prev_w_wait = 1'b0;
    endtask

    // One clock: observe and score at the falling edge, then drive the slave after the rising edge.
    task automatic tick();
        logic aw_hs, w_hs, b_hs;
        logic exp_busy;
        @(negedge i_clk);
        chk("err_pulse", o_err_pulse, exp_pulse);
        chk("err_cnt", o_err_cnt, sat(exp_errs, 255));
        chk("err_cnt_sat", s_err_cnt, sat(exp_errs, 3));
        exp_busy = (exp_aw_q.size() != 0) || (aw_cnt > b_cnt) || (w_cnt > b_cnt);
        chk("busy", o_busy, exp_busy);
        if (prev_aw_wait) begin
            chk("aw_valid_hold", o_aw_valid, 1'b1);
            chk("aw_addr_hold", o_aw_addr, prev_aw_addr);
        end
        if (prev_w_wait) begin
            chk("w_valid_hold", o_w_valid, 1'b1);
            chk("w_data_hold", o_w_data, prev_w_data);
        end
        if (o_b_ready) chk("b_ready_outstanding", (aw_cnt > b_cnt) && (w_cnt > b_cnt), 1'b1);
        if (o_err_pulse) pulse_seen++;

        aw_hs = o_aw_valid && i_aw_ready;
        w_hs  = o_w_valid && i_w_ready;
        b_hs  = o_b_ready && i_b_valid;
        if (aw_hs) begin
            chk("aw_single_outstanding", aw_cnt == b_cnt, 1'b1);
            chk("aw_expected", exp_aw_q.size() != 0, 1'b1);
            if (exp_aw_q.size() != 0) chk("aw_addr", o_aw_addr, exp_aw_q.pop_front());
            aw_cnt++;
        end
        if (w_hs) begin
            chk("w_single_outstanding", w_cnt == b_cnt, 1'b1);
            chk("w_expected", exp_w_q.size() != 0, 1'b1);
            if (exp_w_q.size() != 0) chk("w_data", o_w_data, exp_w_q.pop_front());
            chk("w_strb", o_w_strb, 4'hF);
            chk("w_last", o_w_last, 1'b1);
            w_cnt++;
        end
        exp_pulse = 1'b0;
        if (b_hs) begin
            b_cnt++;
            if (i_b_resp[1]) begin
                exp_errs++;
                exp_pulse = 1'b1;
            end
        end
        accepted = i_msi_valid && o_msi_ready;
        if (accepted) begin
            exp_aw_q.push_back(i_msi_addr);
            exp_w_q.push_back(i_msi_data);
        end
        prev_aw_wait = o_aw_valid && !i_aw_ready;
        prev_w_wait  = o_w_valid && !i_w_ready;
        prev_aw_addr = o_aw_addr;
        prev_w_data  = o_w_data;

        @(posedge i_clk);
        #1;
        if (b_hs) i_b_valid = 1'b0;
        i_aw_ready = pick_ready(aw_mode);
        i_w_ready  = pick_ready(w_mode);
        if (!i_b_valid && b_allow && (aw_cnt > b_cnt) && (w_cnt > b_cnt) &&
            ($urandom_range(0, 99) < b_prob)) begin
            i_b_valid = 1'b1;
            case (resp_mode)
                0:       i_b_resp = 2'b00;
                1:       i_b_resp = 2'b10;
                default: i_b_resp = 2'($urandom);
            endcase
        end
    endtask

    task automatic send_msi(input logic [63:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        i_msi_valid = 1'b1;
        i_msi_addr  = addr;
        i_msi_data  = data;
        do begin
            tick();
            n++;
        end while (!accepted && n < 200);
        chk("msi_accept_timeout", accepted, 1'b1);
        i_msi_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((o_busy || exp_aw_q.size() != 0 || i_b_valid) && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_idle_timeout"}, n < 400, 1'b1);
        chk({tag, "_drained"}, (exp_w_q.size() == 0) && (aw_cnt == b_cnt) && (w_cnt == b_cnt), 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_msi_ready"}, o_msi_ready, 1'b1);
        chk({tag, "_aw_valid"}, o_aw_valid, 1'b0);
        chk({tag, "_w_valid"}, o_w_valid, 1'b0);
        chk({tag, "_b_ready"}, o_b_ready, 1'b0);
        chk({tag, "_aw_addr"}, o_aw_addr, 64'h0);
        chk({tag, "_w_data"}, o_w_data, 32'h0);
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_err_pulse"}, o_err_pulse, 1'b0);
        chk({tag, "_err_cnt"}, o_err_cnt, 8'h0);
        chk({tag, "_err_cnt_sat"}, s_err_cnt, 2'h0);
    endtask

    initial begin
        int acc, b0, p0, a0;
        repeat (2) @(posedge i_clk);
        #1;
        chk_reset_outputs("reset");
        chk("reset_w_strb", o_w_strb, 4'hF);
        ni_rst = 1'b1;
        i_aw_ready = 1'b1;
        i_w_ready  = 1'b1;

        // Single MSI, latency to AW/W valid.
        i_msi_valid = 1'b1;
        i_msi_addr  = 64'h2800_0000;
        i_msi_data  = 32'd5;
        tick();
        chk("t1_accept", accepted, 1'b1);
        i_msi_valid = 1'b0;
        chk("t1_aw_valid_n1", o_aw_valid, 1'b0);
        tick();
        chk("t1_aw_valid_n2", o_aw_valid, 1'b1);
        chk("t1_w_valid_n2", o_w_valid, 1'b1);
        chk("t1_aw_addr", o_aw_addr, 64'h2800_0000);
        chk("t1_w_data", o_w_data, 32'd5);
        wait_idle("t1");
        chk("t1_writes", aw_cnt, 1);
        chk("t1_err_cnt", o_err_cnt, 8'd0);
        chk("t1_busy", o_busy, 1'b0);

        // Fill with AXI stalled: FIFO plus the FSM register hold DEPTH+1.
        aw_mode = 0; w_mode = 0;
        acc = 0;
        for (int k = 0; k < DEPTH + 3; k++) begin
            i_msi_valid = 1'b1;
            i_msi_addr  = 64'h1000 + 64'(k * 4);
            i_msi_data  = 32'hA000 + 32'(k);
            tick();
            if (accepted) acc++;
        end
        i_msi_valid = 1'b0;
        chk("fill_accepts", acc, DEPTH + 1);
        chk("fill_ready_low", o_msi_ready, 1'b0);
        chk("fill_aw_valid", o_aw_valid, 1'b1);
        aw_mode = 1; w_mode = 1;
        wait_idle("fill");
        chk("fill_ready_back", o_msi_ready, 1'b1);

        // W completes well before AW.
        aw_mode = 0; w_mode = 1;
        b0 = b_cnt;
        send_msi(64'h2800_0040, 32'h77);
        repeat (4) tick();
        chk("wfirst_w_valid_low", o_w_valid, 1'b0);
        chk("wfirst_aw_valid_held", o_aw_valid, 1'b1);
        aw_mode = 1;
        wait_idle("wfirst");
        chk("wfirst_one_b", b_cnt - b0, 1);

        // Error responses and saturation of the narrow counter.
        resp_mode = 1;
        p0 = pulse_seen;
        repeat (3) begin
            send_msi({$urandom, $urandom} & ~64'h3, $urandom);
            wait_idle("err");
        end
        tick();
        chk("err_pulses", pulse_seen - p0, 3);
        chk("err_cnt_3", o_err_cnt, 8'd3);
        repeat (2) begin
            send_msi({$urandom, $urandom} & ~64'h3, $urandom);
            wait_idle("err2");
        end
        tick();
        chk("err_cnt_5", o_err_cnt, 8'd5);
        chk("err_cnt_sat_hold", s_err_cnt, 2'd3);
        resp_mode = 0;

        // B valid outside RESP is ignored.
        b_allow = 1'b0;
        i_b_valid = 1'b1;
        i_b_resp  = 2'b10;
        repeat (3) tick();
        chk("spurious_b_ready", o_b_ready, 1'b0);
        chk("spurious_err_cnt", o_err_cnt, 8'd5);
        i_b_valid = 1'b0;
        i_b_resp  = 2'b00;

        // Push in the same cycle as a pop with one entry queued.
        a0 = aw_cnt;
        send_msi(64'h3000_0000, 32'h11);
        repeat (4) tick();
        chk("pp_in_resp", o_b_ready, 1'b1);
        send_msi(64'h3000_0004, 32'h22);
        tick();
        i_b_valid = 1'b1;
        i_b_resp  = 2'b00;
        tick();
        i_msi_valid = 1'b1;
        i_msi_addr  = 64'h3000_0008;
        i_msi_data  = 32'h33;
        tick();
        chk("pp_accept_during_pop", accepted, 1'b1);
        i_msi_valid = 1'b0;
        b_allow = 1'b1;
        wait_idle("pp");
        chk("pp_writes", aw_cnt - a0, 3);

        // Reset during RESP with two queued requests.
        b_allow = 1'b0;
        send_msi(64'h4000_0000, 32'h44);
        send_msi(64'h4000_0004, 32'h55);
        send_msi(64'h4000_0008, 32'h66);
        repeat (3) tick();
        chk("rst_in_resp", o_b_ready, 1'b1);
        chk("rst_busy_before", o_busy, 1'b1);
        #2;
        ni_rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        reset_model();
        i_b_valid = 1'b0;
        @(posedge i_clk);
        #1;
        ni_rst = 1'b1;
        b_allow = 1'b1;
        repeat (20) tick();
        chk("rst_no_stale_aw", aw_cnt, 0);
        chk("rst_no_stale_w", w_cnt, 0);

        // Randomized traffic with random backpressure and responses.
        aw_mode = 2; w_mode = 2; resp_mode = 2; b_prob = 40;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_msi({$urandom, $urandom} & ~64'h3, $urandom);
        end
        wait_idle("rand");
        chk("rand_writes", aw_cnt, 40);
        tick();
        chk("final_err_cnt", o_err_cnt, sat(exp_errs, 255));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
